// File: rtl/mul_iter_pkg.sv
// mul_iter_pkg: Funct3 encodings and FSM state type shared by the iterative multiplier
package mul_iter_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  typedef enum logic [1:0] {IDLE, CALC, FIX} statetype;
endpackage

// File: rtl/mul_iter_if.sv
// mul_iter_if: Execute-side request/response bundle of the iterative multiplier
interface mul_iter_if #(parameter int XLEN = 64);
  logic            FlushE;
  logic            StartE;
  logic [XLEN-1:0] ForwardedSrcAE;
  logic [XLEN-1:0] ForwardedSrcBE;
  logic [2:0]      Funct3E;
  logic            WE;
  logic            MulBusyE;
  logic            ValidM;
  logic [XLEN-1:0] MulResultM;
  modport master (output FlushE, StartE, ForwardedSrcAE, ForwardedSrcBE, Funct3E, WE,
                  input MulBusyE, ValidM, MulResultM);
  modport slave (input FlushE, StartE, ForwardedSrcAE, ForwardedSrcBE, Funct3E, WE,
                 output MulBusyE, ValidM, MulResultM);
endinterface

// File: rtl/mul_iter_pp.sv
// mul_iter_pp: partial product of the shifted multiplicand and one multiplier digit
module mul_iter_pp #(
  parameter int XLEN = 64,
  parameter int BITSPERCYCLE = 2
) (
  input  logic [2*XLEN-1:0]       ashift_i,
  input  logic [BITSPERCYCLE-1:0] digit_i,
  output logic [2*XLEN-1:0]       pp_o
);
  assign pp_o = ashift_i * (2*XLEN)'(digit_i);
endmodule

// File: rtl/mul_iter.sv
// mul_iter: iterative RISC-V M multiplier; MUL_EARLY_OUT_EN stops as soon as the multiplier digits run out
module mul_iter import mul_iter_pkg::*; #(
  parameter int XLEN = 64,
  parameter int BITSPERCYCLE = 2
) (
  input logic clk,
  input logic reset,
  mul_iter_if.slave bus
);
  localparam int N  = XLEN / BITSPERCYCLE;
  localparam int NW = 32 / BITSPERCYCLE;
  localparam int CW = $clog2(N + 1);
  statetype state_q, state_d;
  logic [2*XLEN-1:0] p_q, p_d, a_q, a_d, pp, p_fix;
  logic [XLEN-1:0] b_q, b_d, b_nxt, res_q, res_d, src_a, src_b, mag_a, mag_b, res_sel, w_res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] f3_q, f3_d, f3n;
  logic neg_q, neg_d, w_q, w_d, valid_q, valid_d;
  logic w_op, sign_a, sign_b, load, calc, fix, last, eo_load, eo_calc;
  logic signed [31:0] lo_a, lo_b, lo_p;
  assign w_op = (XLEN == 64) && bus.WE;
  assign f3n = bus.Funct3E[2] ? F3_MUL : bus.Funct3E;
  assign lo_a = bus.ForwardedSrcAE[31:0];
  assign lo_b = bus.ForwardedSrcBE[31:0];
  assign src_a = w_op ? XLEN'(lo_a) : bus.ForwardedSrcAE;
  assign src_b = w_op ? XLEN'(lo_b) : bus.ForwardedSrcBE;
  assign sign_a = w_op ? lo_a[31] : (f3n != F3_MUL && f3n != F3_MULHU) && src_a[XLEN-1];
  assign sign_b = w_op ? lo_b[31] : (f3n == F3_MULH) && src_b[XLEN-1];
  assign mag_a = sign_a ? -src_a : src_a;
  assign mag_b = sign_b ? -src_b : src_b;
  assign b_nxt = b_q >> BITSPERCYCLE;
  assign last = cnt_q == CW'(w_q ? NW - 1 : N - 1);
  assign load = state_q == IDLE && bus.StartE && !bus.FlushE;
  assign calc = state_q == CALC;
  assign fix = state_q == FIX && !bus.FlushE;
  assign p_fix = neg_q ? -p_q : p_q;
  assign lo_p = p_fix[31:0];
  assign w_res = XLEN'(lo_p);
  assign res_sel = w_q ? w_res : f3_q == F3_MUL ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN];
`ifdef MUL_EARLY_OUT_EN
  assign eo_load = mag_b == '0;
  assign eo_calc = b_nxt == '0;
`else
  assign eo_load = 1'b0;
  assign eo_calc = 1'b0;
`endif
  mul_iter_pp #(.XLEN(XLEN), .BITSPERCYCLE(BITSPERCYCLE)) u_pp (
    .ashift_i(a_q),
    .digit_i(b_q[BITSPERCYCLE-1:0]),
    .pp_o(pp)
  );
  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: flush wins, zero multiplier may skip straight to the sign fix-up
  always_comb begin
    state_d = bus.FlushE ? IDLE :
              state_q == IDLE ? (load ? (eo_load ? FIX : CALC) : IDLE) :
              state_q == CALC ? (last || eo_calc ? FIX : CALC) : IDLE;
  end
  // datapath next values: load magnitudes, accumulate one digit per CALC cycle, sign-fix and select in FIX
  always_comb begin
    p_d = load ? '0 : calc ? p_q + pp : p_q;
    a_d = load ? (2*XLEN)'(mag_a) : calc ? a_q << BITSPERCYCLE : a_q;
    b_d = load ? mag_b : calc ? b_nxt : b_q;
    cnt_d = load ? '0 : calc ? cnt_q + 1'b1 : cnt_q;
    neg_d = load ? sign_a ^ sign_b : neg_q;
    f3_d = load ? f3n : f3_q;
    w_d = load ? w_op : w_q;
    valid_d = fix;
    res_d = fix ? res_sel : res_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      f3_q <= '0;
      w_q <= 1'b0;
      valid_q <= 1'b0;
      res_q <= '0;
    end else begin
      p_q <= p_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      f3_q <= f3_d;
      w_q <= w_d;
      valid_q <= valid_d;
      res_q <= res_d;
    end
  end
  assign bus.MulBusyE = state_q != IDLE || bus.StartE;
  assign bus.ValidM = valid_q;
  assign bus.MulResultM = res_q;
endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: directed and randomized checks of mul_iter against a behavioural product model
module tb_mul_iter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mul_iter_if #(.XLEN(32)) b32();
  mul_iter_if #(.XLEN(64)) b64();
  mul_iter #(.XLEN(32), .BITSPERCYCLE(2)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  mul_iter #(.XLEN(64), .BITSPERCYCLE(2)) dut64 (.clk(clk), .reset(reset), .bus(b64));
  int n_chk = 0;
  int n_fail = 0;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  function automatic logic [63:0] model(int xl, int f3, logic w, logic [63:0] a, logic [63:0] b);
    int f;
    logic [127:0] ea, eb, p;
    logic [31:0] lo;
    f = f3 > 3 ? 0 : f3;
    if (xl == 64 && w) begin
      lo = a[31:0] * b[31:0];
      return {{32{lo[31]}}, lo};
    end
    ea = xl == 32 ? {96'b0, a[31:0]} : {64'b0, a};
    eb = xl == 32 ? {96'b0, b[31:0]} : {64'b0, b};
    if ((f == 1 || f == 2) && ea[xl-1]) ea = ea - (128'd1 << xl);
    if (f == 1 && eb[xl-1]) eb = eb - (128'd1 << xl);
    p = ea * eb;
    if (f != 0) p = p >> xl;
    return xl == 32 ? {32'b0, p[31:0]} : p[63:0];
  endfunction
  function automatic int lat(int xl, int f3, logic w, logic [63:0] b);
`ifdef MUL_EARLY_OUT_EN
    logic [63:0] v;
    logic neg;
    int n = 0;
    v = (xl == 64 && w) ? {{32{b[31]}}, b[31:0]} : xl == 32 ? {32'b0, b[31:0]} : b;
    neg = (xl == 64 && w) ? b[31] : (f3 == 1) && v[xl-1];
    if (neg) v = xl == 32 ? (64'd1 << 32) - v : -v;
    while (v != 0) begin
      v = v >> 2;
      n++;
    end
    return n + 2;
`else
    return ((xl == 64 && w) ? 32 : xl) / 2 + 2;
`endif
  endfunction
  function automatic logic [31:0] lo32(logic [63:0] x);
    return x[31:0];
  endfunction
  function automatic logic [63:0] rnd(int xl);
    logic [63:0] v;
    case ($urandom_range(5))
      0: v = '0;
      1: v = '1;
      2: v = 64'd1 << (xl - 1);
      3: v = 64'($urandom_range(15));
      default: v = {$urandom, $urandom};
    endcase
    return xl == 32 ? {32'b0, v[31:0]} : v;
  endfunction
  logic armed = 1'b0;
  logic pend = 1'b0;
  logic v_exp = 1'b0;
  logic [31:0] held = '0;
  logic [31:0] exp_res = '0;
  int rem = 0;
  // reference for the 32-bit unit: operation outcome and its due cycle
  always @(posedge clk) begin
    v_exp <= 1'b0;
    if (reset) begin
      armed <= 1'b1;
      pend <= 1'b0;
      held <= '0;
    end else if (b32.FlushE) pend <= 1'b0;
    else if (pend) begin
      rem <= rem - 1;
      if (rem == 1) begin
        v_exp <= 1'b1;
        held <= exp_res;
        pend <= 1'b0;
      end
    end else if (b32.StartE) begin
      exp_res <= lo32(model(32, int'(b32.Funct3E), b32.WE, 64'(b32.ForwardedSrcAE), 64'(b32.ForwardedSrcBE)));
      rem <= lat(32, int'(b32.Funct3E), b32.WE, 64'(b32.ForwardedSrcBE)) - 1;
      pend <= 1'b1;
    end
  end
  // every-cycle comparison of the 32-bit unit against the reference
  always @(negedge clk) begin
    if (armed) begin
      chk("ValidM", 64'(b32.ValidM), 64'(v_exp));
      chk("MulResultM", 64'(b32.MulResultM), 64'(held));
      chk("MulBusyE", 64'(b32.MulBusyE), 64'(pend || b32.StartE));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input bit big, input int f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                        output int l, output logic [63:0] r);
    if (big) begin
      b64.StartE = 1'b1; b64.Funct3E = 3'(f3); b64.WE = w; b64.ForwardedSrcAE = a; b64.ForwardedSrcBE = b;
    end else begin
      b32.StartE = 1'b1; b32.Funct3E = 3'(f3); b32.WE = w; b32.ForwardedSrcAE = a[31:0]; b32.ForwardedSrcBE = b[31:0];
    end
    tick();
    b32.StartE = 1'b0;
    b64.StartE = 1'b0;
    l = 1;
    while (!(big ? b64.ValidM : b32.ValidM) && l < 200) begin
      tick();
      l++;
    end
    r = big ? b64.MulResultM : {32'b0, b32.MulResultM};
  endtask
  localparam int ND = 13;
  localparam int DBIG [ND] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  localparam int DF3 [ND] = '{3, 0, 2, 1, 0, 0, 0, 5, 1, 0, 3, 1, 0};
  localparam int DW [ND] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  localparam logic [63:0] DA [ND] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h80000000, 64'h80000000,
    64'd7, 64'd5, 64'h10, 64'hFFFFFFFE, 64'h1_7FFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000000, 64'h1_00000000};
  localparam logic [63:0] DB [ND] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h80000000, 64'hFFFFFFFF,
    64'd3, 64'd0, 64'h10, 64'd3, 64'd2, 64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000000, 64'h1_00000000};
  localparam logic [63:0] DR [ND] = '{64'hFFFFFFFE, 64'h1, 64'hFFFFFFFF, 64'h40000000, 64'h80000000,
    64'h15, 64'h0, 64'h100, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFE, 64'h40000000_00000000, 64'h0};
`ifdef MUL_EARLY_OUT_EN
  localparam int DL [ND] = '{18, 18, 18, 18, 18, 3, 2, 5, 3, 3, 34, 34, 19};
`else
  localparam int DL [ND] = '{18, 18, 18, 18, 18, 18, 18, 18, 18, 18, 34, 34, 34};
`endif
  initial begin
    int l;
    int nv;
    logic [63:0] r;
    b32.FlushE = 1'b0; b32.StartE = 1'b0; b32.WE = 1'b0; b32.Funct3E = '0;
    b32.ForwardedSrcAE = '0; b32.ForwardedSrcBE = '0;
    b64.FlushE = 1'b0; b64.StartE = 1'b0; b64.WE = 1'b0; b64.Funct3E = '0;
    b64.ForwardedSrcAE = '0; b64.ForwardedSrcBE = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset ValidM32", 64'(b32.ValidM), 64'd0);
    chk("reset Result32", 64'(b32.MulResultM), 64'd0);
    chk("reset Busy32", 64'(b32.MulBusyE), 64'd0);
    chk("reset ValidM64", 64'(b64.ValidM), 64'd0);
    chk("reset Result64", b64.MulResultM, 64'd0);
    chk("reset Busy64", 64'(b64.MulBusyE), 64'd0);
    chk("model MULHU", model(32, 3, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF), 64'hFFFFFFFE);
    chk("model MULW", model(64, 0, 1'b1, 64'h1_7FFFFFFF, 64'd2), 64'hFFFFFFFF_FFFFFFFE);
    for (int i = 0; i < ND; i++) begin
      run_op(DBIG[i] != 0, DF3[i], DW[i] != 0, DA[i], DB[i], l, r);
      chk($sformatf("dir%0d result", i), r, DR[i]);
      chk($sformatf("dir%0d latency", i), 64'(l), 64'(DL[i]));
    end
    tick();
    b32.StartE = 1'b1; b32.Funct3E = 3'd0; b32.ForwardedSrcAE = 32'd3; b32.ForwardedSrcBE = 32'hFFFFFFFF;
    tick();
    b32.StartE = 1'b0;
    tick();
    b32.StartE = 1'b1; b32.ForwardedSrcAE = 32'd9; b32.ForwardedSrcBE = 32'd9;
    tick();
    b32.StartE = 1'b0;
    repeat (2) tick();
    b32.FlushE = 1'b1;
    tick();
    b32.FlushE = 1'b0;
    chk("flush busy", 64'(b32.MulBusyE), 64'd0);
    nv = 0;
    repeat (25) begin
      tick();
      nv += int'(b32.ValidM);
    end
    chk("flush no ValidM", 64'(nv), 64'd0);
    chk("flush retains result", 64'(b32.MulResultM), 64'hFFFFFFFF);
    for (int c = 0; c < 1500; c++) begin
      b32.StartE = $urandom_range(3) == 0;
      b32.FlushE = $urandom_range(60) == 0;
      b32.Funct3E = 3'($urandom_range(7));
      b32.WE = 1'($urandom_range(1));
      r = rnd(32);
      b32.ForwardedSrcAE = r[31:0];
      r = rnd(32);
      b32.ForwardedSrcBE = r[31:0];
      reset = c == 700;
      tick();
    end
    b32.StartE = 1'b0;
    b32.FlushE = 1'b0;
    reset = 1'b0;
    repeat (25) tick();
    for (int i = 0; i < 30; i++) begin
      logic [63:0] a, b;
      int f;
      logic w;
      a = rnd(64);
      b = rnd(64);
      f = $urandom_range(7);
      w = 1'($urandom_range(1));
      run_op(1'b1, f, w, a, b, l, r);
      chk($sformatf("rnd64_%0d result", i), r, model(64, f, w, a, b));
      chk($sformatf("rnd64_%0d latency", i), 64'(l), 64'(lat(64, f, w, b)));
      repeat ($urandom_range(2)) tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
